// File: rtl/cr_io_pkg.sv
// Shared constants and bus payload types for the core I/O register blocks.
package cr_io_pkg;

  localparam int unsigned BUS_W      = 16;
  localparam int unsigned DBNC_CNT_W = 16;

  typedef enum logic {
    ADDR_DATA    = 1'b0,
    ADDR_CHANGED = 1'b1
  } addr_e;

  typedef struct packed {
    logic             valid;
    logic [BUS_W-1:0] data;
  } rd_rsp_t;

endpackage

// File: rtl/pin_debounce.sv
// One board pin: synchronizer chain followed by a counter-based debouncer.
// o_update_c pulses on the edge where the stable level is about to change.
module pin_debounce
  import cr_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_pin,
  output logic o_stable,
  output logic o_update_c
);

  localparam logic [DBNC_CNT_W-1:0] CNT_LAST = DBNC_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DBNC_CNT_W-1:0]  cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   pin_sync;

  assign pin_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], i_pin};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  // Count only while the synchronized level disagrees; any agreement restarts the window.
  always_comb begin
    cnt_d      = '0;
    stable_d   = stable_q;
    o_update_c = 1'b0;
    if (pin_sync != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d   = pin_sync;
        o_update_c = 1'b1;
      end else begin
        cnt_d = cnt_q + DBNC_CNT_W'(1);
      end
    end
  end

  assign o_stable = stable_q;

endmodule

// File: rtl/input_port.sv
// Debounced input port with DATA / sticky CHANGED registers on a one-cycle read bus.
// Define INPUT_PORT_IRQ_EN to add the o_irq level interrupt output.
module input_port
  import cr_io_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_pins,
  input  logic             i_rd,
  input  logic             i_addr,
  output logic [BUS_W-1:0] o_rd_data,
`ifdef INPUT_PORT_IRQ_EN
  output logic             o_rd_valid,
  output logic             o_irq
`else
  output logic             o_rd_valid
`endif
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] update_c;
  logic [WIDTH-1:0] changed_q, changed_d;
  logic [WIDTH-1:0] clr_mask_c;
  rd_rsp_t          rsp_q, rsp_d;

  for (genvar g = 0; g < WIDTH; g++) begin : g_pin
    pin_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_pin_debounce (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_pin     (i_pins[g]),
      .o_stable  (stable[g]),
      .o_update_c(update_c[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      changed_q <= '0;
      rsp_q     <= '0;
    end else begin
      changed_q <= changed_d;
      rsp_q     <= rsp_d;
    end
  end

  // A CHANGED read clears only the bits it returned; a same-edge update re-sets its bit.
  always_comb begin
    rsp_d      = '0;
    clr_mask_c = '0;
    if (i_rd) begin
      rsp_d.valid = 1'b1;
      if (addr_e'(i_addr) == ADDR_CHANGED) begin
        rsp_d.data = BUS_W'(changed_q);
        clr_mask_c = changed_q;
      end else begin
        rsp_d.data = BUS_W'(stable);
      end
    end
    changed_d = (changed_q & ~clr_mask_c) | update_c;
  end

  assign o_rd_data  = rsp_q.data;
  assign o_rd_valid = rsp_q.valid;

`ifdef INPUT_PORT_IRQ_EN
  logic irq_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |changed_q;
    end
  end

  assign o_irq = irq_q;
`endif

endmodule

// File: tb/tb_input_port.sv
// Directed bench for input_port with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Pin edges land on the stable register 6 edges after being driven.
module tb_input_port;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] pins;
  logic             rd;
  logic             addr;
  logic [15:0]      rd_data;
  logic             rd_valid;
`ifdef INPUT_PORT_IRQ_EN
  logic             irq;
`endif

  int checks = 0;
  int errors = 0;

  input_port #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2)
  ) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_pins    (pins),
    .i_rd      (rd),
    .i_addr    (addr),
    .o_rd_data (rd_data),
`ifdef INPUT_PORT_IRQ_EN
    .o_rd_valid(rd_valid),
    .o_irq     (irq)
`else
    .o_rd_valid(rd_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Strobe for one cycle; returns what appears one edge later.
  task automatic do_read(input logic a, output logic [15:0] d, output logic v);
    rd   = 1'b1;
    addr = a;
    @(posedge clk);
    #1;
    rd = 1'b0;
    d  = rd_data;
    v  = rd_valid;
  endtask

  task automatic test_reset;
    logic [15:0] d;
    logic        v;
    reset = 1'b1;
    pins  = '0;
    rd    = 1'b1;
    addr  = 1'b0;
    idle(3);
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_out valid=%b data=%h exp valid=0 data=0000", rd_valid, rd_data);
    end
`ifdef INPUT_PORT_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got=%b exp=0", irq);
    end
`endif
    reset = 1'b0;
    rd    = 1'b0;
    idle(1);
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_in_reset valid=%b exp=0", rd_valid);
    end
    do_read(1'b0, d, v);
    checks++;
    if (v !== 1'b1 || d !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data got=%h/%b exp=0000/1", d, v);
    end
    do_read(1'b1, d, v);
    checks++;
    if (v !== 1'b1 || d !== 16'h0000) begin
      errors++;
      $display("FAIL reset_changed got=%h/%b exp=0000/1", d, v);
    end
  endtask

  // Back-to-back DATA reads straddle the acceptance edge of pin0.
  task automatic test_debounce_edge;
    logic [15:0] d, exp;
    logic        v;
    pins = 8'h01;
    for (int k = 0; k < 8; k++) begin
      do_read(1'b0, d, v);
      exp = (k >= 6) ? 16'h0001 : 16'h0000;
      checks++;
      if (v !== 1'b1 || d !== exp) begin
        errors++;
        $display("FAIL edge_rd%0d got=%h/%b exp=%h/1", k, d, v, exp);
      end
    end
    idle(1);
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 16'h0) begin
      errors++;
      $display("FAIL idle_zero valid=%b data=%h exp 0/0000", rd_valid, rd_data);
    end
    do_read(1'b1, d, v);
    checks++;
    if (v !== 1'b1 || d !== 16'h0001) begin
      errors++;
      $display("FAIL edge_changed got=%h/%b exp=0001/1", d, v);
    end
  endtask

  task automatic test_glitch;
    logic [15:0] d;
    logic        v;
    pins = 8'h09;
    idle(3);
    pins = 8'h01;
    idle(10);
    do_read(1'b0, d, v);
    checks++;
    if (v !== 1'b1 || d !== 16'h0001) begin
      errors++;
      $display("FAIL glitch_data got=%h/%b exp=0001/1", d, v);
    end
    do_read(1'b1, d, v);
    checks++;
    if (v !== 1'b1 || d !== 16'h0000) begin
      errors++;
      $display("FAIL glitch_changed got=%h/%b exp=0000/1", d, v);
    end
`ifdef INPUT_PORT_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL glitch_irq got=%b exp=0", irq);
    end
`endif
  endtask

  task automatic test_changed_clear;
    logic [15:0] d;
    logic        v;
    pins = 8'h0B;
    idle(10);
    do_read(1'b1, d, v);
    checks++;
    if (v !== 1'b1 || d !== 16'h000A) begin
      errors++;
      $display("FAIL clr_first got=%h/%b exp=000A/1", d, v);
    end
    do_read(1'b1, d, v);
    checks++;
    if (v !== 1'b1 || d !== 16'h0000) begin
      errors++;
      $display("FAIL clr_second got=%h/%b exp=0000/1", d, v);
    end
    do_read(1'b0, d, v);
    checks++;
    if (v !== 1'b1 || d !== 16'h000B) begin
      errors++;
      $display("FAIL clr_data got=%h/%b exp=000B/1", d, v);
    end
  endtask

  // CHANGED read sampled on the very edge pin1's flag sets.
  task automatic test_set_wins;
    logic [15:0] d;
    logic        v;
    pins = 8'h09;
    idle(5);
    do_read(1'b1, d, v);
    checks++;
    if (v !== 1'b1 || d !== 16'h0000) begin
      errors++;
      $display("FAIL setwin_same got=%h/%b exp=0000/1", d, v);
    end
    do_read(1'b1, d, v);
    checks++;
    if (v !== 1'b1 || d !== 16'h0002) begin
      errors++;
      $display("FAIL setwin_next got=%h/%b exp=0002/1", d, v);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d;
    logic        v;
    logic [15:0] exp_d [4] = '{16'h000C, 16'h0005, 16'h0000, 16'h000C};
    logic        exp_a [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    pins = 8'h0C;
    idle(10);
    for (int k = 0; k < 4; k++) begin
      do_read(exp_a[k], d, v);
      checks++;
      if (v !== 1'b1 || d !== exp_d[k]) begin
        errors++;
        $display("FAIL b2b_rd%0d got=%h/%b exp=%h/1", k, d, v, exp_d[k]);
      end
    end
  endtask

  // Reset lands with pin0's count at 2; everything restarts from release.
  task automatic test_reset_mid;
    logic [15:0] d, exp;
    logic        v;
    pins = 8'h0D;
    idle(4);
    reset = 1'b1;
    rd    = 1'b1;
    addr  = 1'b0;
    idle(2);
    reset = 1'b0;
    rd    = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 16'h0) begin
      errors++;
      $display("FAIL midrst_out valid=%b data=%h exp 0/0000", rd_valid, rd_data);
    end
    idle(1);
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_rd valid=%b exp=0", rd_valid);
    end
    for (int k = 1; k < 8; k++) begin
      do_read(1'b0, d, v);
      exp = (k >= 6) ? 16'h000D : 16'h0000;
      checks++;
      if (v !== 1'b1 || d !== exp) begin
        errors++;
        $display("FAIL midrst_rd%0d got=%h/%b exp=%h/1", k, d, v, exp);
      end
    end
    do_read(1'b1, d, v);
    checks++;
    if (v !== 1'b1 || d !== 16'h000D) begin
      errors++;
      $display("FAIL midrst_changed got=%h/%b exp=000D/1", d, v);
    end
  endtask

`ifdef INPUT_PORT_IRQ_EN
  task automatic test_irq;
    logic [15:0] d;
    logic        v;
    pins = 8'h0F;
    idle(6);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_flag_edge got=%b exp=0", irq);
    end
    idle(1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_rise got=%b exp=1", irq);
    end
    do_read(1'b1, d, v);
    checks++;
    if (v !== 1'b1 || d !== 16'h0002 || irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_read got=%h/%b irq=%b exp=0002/1 irq=1", d, v, irq);
    end
    idle(1);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_fall got=%b exp=0", irq);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_debounce_edge();
    test_glitch();
    test_changed_clear();
    test_set_wins();
    test_back_to_back();
    test_reset_mid();
`ifdef INPUT_PORT_IRQ_EN
    test_irq();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_port.md
INPUT_PORT -- requirements
Module: input_port

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of input pins.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16000 (1 ms at 16 MHz): consecutive cycles a changed pin level must hold before acceptance; legal range 2..65535.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth; legal range 2..3.
REQ-004 i_clk  input  1  system clock; the only clock.
REQ-005 i_reset  input  1  reset; synchronous, active-high.
REQ-006 i_pins  input  WIDTH  asynchronous board pin levels.
REQ-007 i_rd  input  1  one-cycle read strobe from the core.
REQ-008 i_addr  input  1  register select: 0 = DATA, 1 = CHANGED.
REQ-009 o_rd_data  output  16  read result, zero-extended from WIDTH.
REQ-010 o_rd_valid  output  1  high for exactly one cycle when o_rd_data is valid.
REQ-011 o_irq  output  1  level interrupt; present only with INPUT_PORT_IRQ_EN.

Function
REQ-012 Each pin SHALL pass through a SYNC_STAGES flop chain before any other logic.
REQ-013 Per bit, a 16-bit counter SHALL clear whenever the synchronized level equals the stable level.
REQ-014 Per bit, the counter SHALL increment while the synchronized level differs from the stable level.
REQ-015 When a mismatching bit's counter equals DEBOUNCE_CYCLES-1, the stable bit SHALL take the synchronized level, and the counter SHALL clear, on that same edge.
REQ-016 A clean pin edge SHALL reach the stable register exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles later.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL cause no change to the stable level.
REQ-018 Each stable-bit update SHALL set that bit's sticky CHANGED flag on the same edge.
REQ-019 DATA read: o_rd_data SHALL return the stable levels.
REQ-020 CHANGED read: o_rd_data SHALL return the flags, then clear all flags that were returned.
REQ-021 A flag set on the same edge as a CHANGED read SHALL remain set (set wins over clear).
REQ-022 Read latency SHALL be one cycle: o_rd_data and o_rd_valid are registered from i_rd.
REQ-023 When o_rd_valid is low, o_rd_data SHALL be zero.
REQ-024 Back-to-back i_rd on consecutive cycles SHALL each produce one valid response, in order.

Reset
REQ-025 While i_reset is high, SHALL clear synchronizer flops, stable register, counters, CHANGED flags, o_rd_data, o_rd_valid and o_irq to 0.
REQ-026 Reset mid-debounce SHALL discard the pending count.
REQ-027 A pin held high through reset SHALL become stable high SYNC_STAGES+DEBOUNCE_CYCLES cycles after reset release and SHALL set its CHANGED flag.
REQ-028 An i_rd asserted during reset SHALL produce no response.

Configuration
REQ-029 With INPUT_PORT_IRQ_EN defined, o_irq SHALL be a registered OR of all CHANGED flags, asserting one cycle after a flag sets and deasserting one cycle after flags clear.
REQ-030 Without INPUT_PORT_IRQ_EN, the o_irq port SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Package cr_io_pkg SHALL hold the bus data width constant (16) and the address encodings ADDR_DATA=0 and ADDR_CHANGED=1.
REQ-032 Per-bit synchronizer and debounce logic SHALL be one sub-module, pin_debounce, instantiated WIDTH times by generate.

Verification (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-033 Pin0 0->1 at cycle 10 -> DATA read returns 0x0000 at cycle 15 and 0x0001 at cycle 16+.
REQ-034 Pin3 high for 3 cycles, then low -> DATA and CHANGED stay 0x0000; o_irq stays 0.
REQ-035 Pins 0x0A settle; CHANGED read -> returns 0x000A; next CHANGED read -> returns 0x0000.
REQ-036 Pin1 flag sets on the same edge as a CHANGED read -> that read omits bit1; the following read returns 0x0002.
REQ-037 i_reset asserted at debounce count 2, pin held high -> after release, stable updates exactly 6 cycles later.
REQ-038 IRQ_EN build: pin change -> o_irq rises the cycle after the flag sets and falls the cycle after the CHANGED read.
